// File: rtl/pipe_pkg.sv
// Shared hazard codes, operand-select encodings and forwarding FSM states.
// Used by fwd_ctrl; optional statistics are enabled with FWD_CTRL_STATS_EN.
package pipe_pkg;

    localparam logic [3:0] HZ_NONE     = 4'h0;
    localparam logic [3:0] HZ_D1_R_RS  = 4'h1;
    localparam logic [3:0] HZ_D1_R_RT  = 4'h2;
    localparam logic [3:0] HZ_D1_L_RS  = 4'h3;
    localparam logic [3:0] HZ_D1_L_RT  = 4'h4;
    localparam logic [3:0] HZ_D2_R_RS  = 4'h5;
    localparam logic [3:0] HZ_D2_R_RT  = 4'h6;
    localparam logic [3:0] HZ_D2_L_RS  = 4'h7;
    localparam logic [3:0] HZ_D2_L_RT  = 4'h8;
    localparam logic [3:0] HZ_D3_R_RS  = 4'h9;
    localparam logic [3:0] HZ_D3_R_RT  = 4'hA;
    localparam logic [3:0] HZ_D3_L_RS  = 4'hB;
    localparam logic [3:0] HZ_D3_L_RT  = 4'hC;
    localparam logic [3:0] HZ_RSV_LO   = 4'hD;

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       is_load1;
        logic       reserved;
        logic       capture;
    } decode_t;

    // Odd codes steer operand A, even codes operand B; code 0 steers neither.
    function automatic decode_t decode_conf(input logic [3:0] code);
        decode_t    d;
        logic [1:0] sel;
        d   = '0;
        sel = SEL_RF;
        case (code)
            HZ_D1_R_RS, HZ_D1_R_RT: sel = SEL_MEM;
            HZ_D1_L_RS, HZ_D1_L_RT: d.is_load1 = 1'b1;
            HZ_D2_R_RS, HZ_D2_R_RT,
            HZ_D2_L_RS, HZ_D2_L_RT: sel = SEL_WB;
            HZ_D3_R_RS, HZ_D3_R_RT,
            HZ_D3_L_RS, HZ_D3_L_RT: begin
                sel       = SEL_HOLD;
                d.capture = 1'b1;
            end
            default: d.reserved = (code >= HZ_RSV_LO);
        endcase
        if (code != HZ_NONE) begin
            if (code[0]) d.sel_a = sel;
            else         d.sel_b = sel;
        end
        return d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 16'd0;
        else if (en && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding/stall controller: registers EX operand selects, inserts one load-use bubble.
// Define FWD_CTRL_STATS_EN to add StallCount/FwdCount saturating statistics outputs.
//
// state    | meaning
// ST_RUN   | normal issue; a dist-1 load hazard stalls F/D and flushes E
// ST_STALL | one bubble cycle; held D instruction is re-evaluated
module fwd_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  conftype,
    input  logic        HoldIn,
    input  logic [31:0] ResultW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [31:0] WbHoldE,
    output logic        ErrCode
`ifdef FWD_CTRL_STATS_EN
    ,
    output logic [15:0] StallCount,
    output logic [15:0] FwdCount
`endif
);

    state_t     state;
    decode_t    dec;
    logic       stall_req;
    logic       err_set;

    always_comb begin
        dec       = decode_conf(conftype);
        stall_req = (state == ST_RUN) && dec.is_load1;
        // A dist-1 load seen while already stalled should never happen.
        err_set   = dec.reserved || ((state == ST_STALL) && dec.is_load1);
        StallF    = !rst && (HoldIn || stall_req);
        StallD    = StallF;
        FlushE    = !rst && !HoldIn && stall_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            ForwardAE <= SEL_RF;
            ForwardBE <= SEL_RF;
            WbHoldE   <= 32'd0;
            ErrCode   <= 1'b0;
        end else if (!HoldIn) begin
            state     <= stall_req ? ST_STALL : ST_RUN;
            ForwardAE <= dec.sel_a;
            ForwardBE <= dec.sel_b;
            if (dec.capture)
                WbHoldE <= ResultW;
            if (err_set)
                ErrCode <= 1'b1;
        end
    end

`ifdef FWD_CTRL_STATS_EN
    logic stall_en;
    logic fwd_en;

    assign stall_en = !HoldIn && stall_req;
    assign fwd_en   = !HoldIn && ((dec.sel_a != SEL_RF) || (dec.sel_b != SEL_RF));

    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (StallCount)
    );

    sat_counter u_fwd_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (fwd_en),
        .count (FwdCount)
    );
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed self-checking bench for fwd_ctrl (statistics checks only with FWD_CTRL_STATS_EN).
module tb_fwd_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  conftype;
    logic        HoldIn;
    logic [31:0] ResultW;
    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] WbHoldE;
    logic        ErrCode;
`ifdef FWD_CTRL_STATS_EN
    logic [15:0] StallCount;
    logic [15:0] FwdCount;
`endif

    int checks = 0;
    int errors = 0;

    fwd_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .conftype  (conftype),
        .HoldIn    (HoldIn),
        .ResultW   (ResultW),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .WbHoldE   (WbHoldE),
        .ErrCode   (ErrCode)
`ifdef FWD_CTRL_STATS_EN
        ,
        .StallCount(StallCount),
        .FwdCount  (FwdCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; conftype = 4'h3; HoldIn = 1'b0; ResultW = 32'h1111_2222;
        tick();
        #1;
        checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL reset_stallf got %b exp 0", StallF); end
        checks++; if (FlushE !== 1'b0) begin errors++; $display("FAIL reset_flushe got %b exp 0", FlushE); end
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL reset_sel got %b exp 0000", {ForwardAE, ForwardBE}); end
        checks++; if (WbHoldE !== 32'd0) begin errors++; $display("FAIL reset_wbhold got %h exp 0", WbHoldE); end
        checks++; if (ErrCode !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ErrCode); end
        conftype = 4'h0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dist1_rtype();
        conftype = 4'h1;
        #1;
        checks++; if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL d1_nostall got %b exp 000", {StallF, StallD, FlushE}); end
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b1000) begin errors++; $display("FAIL d1_rs_sel got %b exp 1000", {ForwardAE, ForwardBE}); end
        conftype = 4'h2;
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0010) begin errors++; $display("FAIL d1_rt_sel got %b exp 0010", {ForwardAE, ForwardBE}); end
    endtask

    task automatic test_load_stall();
        conftype = 4'h1;
        tick();
        conftype = 4'h4;
        #1;
        checks++; if ({StallF, StallD, FlushE} !== 3'b111) begin errors++; $display("FAIL ld_stall got %b exp 111", {StallF, StallD, FlushE}); end
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL ld_bubble got %b exp 0000", {ForwardAE, ForwardBE}); end
        conftype = 4'h8;
        #1;
        checks++; if ({StallF, FlushE} !== 2'b00) begin errors++; $display("FAIL ld_stall_cycle got %b exp 00", {StallF, FlushE}); end
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0001) begin errors++; $display("FAIL ld_resume_sel got %b exp 0001", {ForwardAE, ForwardBE}); end
        // A fresh load hazard must stall again, which only happens from RUN.
        conftype = 4'h3;
        #1;
        checks++; if (FlushE !== 1'b1) begin errors++; $display("FAIL ld_back_run got %b exp 1", FlushE); end
        tick();
        conftype = 4'h7;
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin errors++; $display("FAIL ld_d2_rs got %b exp 0100", {ForwardAE, ForwardBE}); end
        checks++; if (ErrCode !== 1'b0) begin errors++; $display("FAIL ld_noerr got %b exp 0", ErrCode); end
    endtask

    task automatic test_wbhold();
        conftype = 4'h9; ResultW = 32'hDEADBEEF;
        tick();
        checks++; if (ForwardAE !== 2'b11) begin errors++; $display("FAIL wb_sel got %b exp 11", ForwardAE); end
        checks++; if (WbHoldE !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_capture got %h exp deadbeef", WbHoldE); end
        conftype = 4'h5; ResultW = 32'h1234_5678;
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin errors++; $display("FAIL wb_d2_sel got %b exp 0100", {ForwardAE, ForwardBE}); end
        checks++; if (WbHoldE !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_keep got %h exp deadbeef", WbHoldE); end
        conftype = 4'hC; ResultW = 32'hCAFE_F00D;
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0011) begin errors++; $display("FAIL wb_d3l_sel got %b exp 0011", {ForwardAE, ForwardBE}); end
        checks++; if (WbHoldE !== 32'hCAFEF00D) begin errors++; $display("FAIL wb_recapture got %h exp cafef00d", WbHoldE); end
    endtask

    task automatic test_hold();
        conftype = 4'h1; ResultW = 32'h0;
        tick();
        HoldIn = 1'b1; conftype = 4'h3; ResultW = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({StallF, StallD, FlushE} !== 3'b110) begin errors++; $display("FAIL hold_ctl[%0d] got %b exp 110", i, {StallF, StallD, FlushE}); end
            tick();
            checks++; if ({ForwardAE, ForwardBE} !== 4'b1000) begin errors++; $display("FAIL hold_sel[%0d] got %b exp 1000", i, {ForwardAE, ForwardBE}); end
        end
        conftype = 4'hB;
        tick();
        checks++; if (WbHoldE !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_wb got %h exp cafef00d", WbHoldE); end
        conftype = 4'hF;
        tick();
        checks++; if (ErrCode !== 1'b0) begin errors++; $display("FAIL hold_err got %b exp 0", ErrCode); end
        HoldIn = 1'b0; conftype = 4'h3;
        #1;
        checks++; if (FlushE !== 1'b1) begin errors++; $display("FAIL hold_state_run got %b exp 1", FlushE); end
        tick();
    endtask

    task automatic test_stall_err();
        // Now in STALL: a repeated dist-1 load code is illegal.
        conftype = 4'h3;
        #1;
        checks++; if ({StallF, FlushE} !== 2'b00) begin errors++; $display("FAIL serr_ctl got %b exp 00", {StallF, FlushE}); end
        tick();
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL serr_sel got %b exp 0000", {ForwardAE, ForwardBE}); end
        checks++; if (ErrCode !== 1'b1) begin errors++; $display("FAIL serr_err got %b exp 1", ErrCode); end
        conftype = 4'h0;
        tick();
    endtask

    task automatic test_reserved_and_reset();
        do_reset();
        checks++; if (ErrCode !== 1'b0) begin errors++; $display("FAIL rsv_clear got %b exp 0", ErrCode); end
        conftype = 4'hE;
        tick();
        checks++; if ({ErrCode, ForwardAE, ForwardBE} !== 5'b10000) begin errors++; $display("FAIL rsv_set got %b exp 10000", {ErrCode, ForwardAE, ForwardBE}); end
        conftype = 4'h0;
        tick(); tick();
        checks++; if (ErrCode !== 1'b1) begin errors++; $display("FAIL rsv_sticky got %b exp 1", ErrCode); end
        conftype = 4'h9; ResultW = 32'h0BAD_F00D;
        tick();
        conftype = 4'h4;
        tick();
        rst = 1'b1;
        #1;
        checks++; if ({StallF, StallD, FlushE, ForwardAE, ForwardBE, ErrCode} !== 8'd0) begin errors++; $display("FAIL rst_mid_ctl got %b exp 00000000", {StallF, StallD, FlushE, ForwardAE, ForwardBE, ErrCode}); end
        checks++; if (WbHoldE !== 32'd0) begin errors++; $display("FAIL rst_mid_wb got %h exp 0", WbHoldE); end
        rst = 1'b0;
        conftype = 4'h3;
        #1;
        checks++; if (FlushE !== 1'b1) begin errors++; $display("FAIL rst_mid_run got %b exp 1", FlushE); end
        conftype = 4'h0;
        tick();
    endtask

`ifdef FWD_CTRL_STATS_EN
    task automatic test_stats();
        do_reset();
        conftype = 4'h4;
        tick();
        conftype = 4'h0;
        tick();
        checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL stat_stall got %h exp 0001", StallCount); end
        checks++; if (FwdCount !== 16'd0) begin errors++; $display("FAIL stat_fwd0 got %h exp 0000", FwdCount); end
        conftype = 4'h1;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        checks++; if (FwdCount !== 16'hFFFF) begin errors++; $display("FAIL stat_sat got %h exp ffff", FwdCount); end
        conftype = 4'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_dist1_rtype();
        test_load_stall();
        test_wbhold();
        test_hold();
        test_stall_err();
        test_reserved_and_reset();
`ifdef FWD_CTRL_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: conftype  in  4  resolved hazard code for instruction in D, from the distance-1/2/3 detector chain.
REQ-004 SHALL have ports: HoldIn  in  1  external pipeline freeze (memory wait); highest priority.
REQ-005 SHALL have ports: ResultW  in  32  value being written back this cycle.
REQ-006 SHALL have ports: StallF, StallD  out  1 each  hold PC and IF/ID.
REQ-007 SHALL have ports: FlushE  out  1  insert bubble into ID/EX.
REQ-008 SHALL have ports: ForwardAE, ForwardBE  out  2 each  registered EX operand selects.
REQ-009 SHALL have ports: WbHoldE  out  32  captured write-back value for select 11.
REQ-010 SHALL have ports: ErrCode  out  1  sticky flag, reserved code seen.

Function
REQ-011 SHALL decode conftype: 0 none; 1/2 dist1 R-type rs/rt; 3/4 dist1 load rs/rt; 5/6 dist2 R-type rs/rt; 7/8 dist2 load rs/rt; 9/a dist3 R-type rs/rt; b/c dist3 load rs/rt; d-f reserved.
REQ-012 SHALL use select encoding 00 register file, 01 WB result, 10 MEM ALU result, 11 WbHoldE; odd codes select operand A, even codes operand B (except 0).
REQ-013 SHALL map codes to next selects: 1/2 -> 10; 5-8 -> 01; 9-c -> 11; 0, d-f -> 00; non-selected operand -> 00.
REQ-014 SHALL register ForwardAE/BE at the clock edge that moves the D instruction into E (latency 1).
REQ-015 SHALL capture ResultW into WbHoldE on the same edge when code is 9-c; otherwise WbHoldE holds.
REQ-016 SHALL implement two-state FSM RUN/STALL; RUN -> STALL on code 3/4; STALL -> RUN unconditionally after one cycle.
REQ-017 SHALL assert StallF, StallD, FlushE combinationally in the RUN cycle that sees code 3/4; ForwardAE/BE load 00 on that edge (bubble).
REQ-018 SHALL, in STALL, evaluate conftype for the held instruction normally (expected 7/8 -> 01); a code 3/4 in STALL SHALL be treated as 00 and set ErrCode.
REQ-019 SHALL, when HoldIn=1, freeze FSM, selects, WbHoldE and counters, and drive StallF=StallD=1, FlushE=0.
REQ-020 SHALL set ErrCode on any reserved code when not held; it clears only on reset.

Reset
REQ-021 SHALL on rst: state RUN, ForwardAE=ForwardBE=00, WbHoldE=0, ErrCode=0, counters 0; StallF/StallD/FlushE=0 while rst high.
REQ-022 SHALL on rst asserted during STALL return to RUN without completing the stall.

Configuration
REQ-023 SHALL, with FWD_CTRL_STATS_EN defined, add outputs StallCount[15:0] (increments per RUN->STALL) and FwdCount[15:0] (increments per edge with non-00 select), both saturating at 16'hFFFF.
REQ-024 SHALL, without FWD_CTRL_STATS_EN, omit those ports and logic entirely; all other behaviour identical.

Structure
REQ-025 SHALL place hazard code constants, select encodings and the RUN/STALL state encoding in shared package pipe_pkg.
REQ-026 SHALL implement counters as sub-module sat_counter (16-bit, enable, saturate), instantiated twice under the macro.

Verification
REQ-027 SHALL cover: conftype=1 in RUN -> next cycle ForwardAE=10, ForwardBE=00, no stall.
REQ-028 SHALL cover: conftype=4 in RUN -> StallF=StallD=FlushE=1 same cycle, selects 00 next; then conftype=8 -> ForwardBE=01, state RUN.
REQ-029 SHALL cover: conftype=9 with ResultW=32'hDEADBEEF -> next cycle ForwardAE=11, WbHoldE=32'hDEADBEEF.
REQ-030 SHALL cover: HoldIn=1 for 3 cycles with conftype=3 -> no state change, StallF=1, FlushE=0, selects unchanged.
REQ-031 SHALL cover: conftype=4'hE -> ErrCode=1 persists until rst; rst pulse mid-STALL -> RUN, all outputs 0.
REQ-032 SHALL cover (STATS_EN): 70000 forwarding cycles -> FwdCount=16'hFFFF, no wrap.
